// File: rtl/alu_mdu_pkg.sv
// Shared definitions for the alu_mdu execute unit: op codes, FSM states and
// width-parametrised constants used by the divide special cases.
package alu_mdu_pkg;

   localparam logic [4:0] OP_ADD    = 5'd0;
   localparam logic [4:0] OP_SUB    = 5'd1;
   localparam logic [4:0] OP_XOR    = 5'd2;
   localparam logic [4:0] OP_OR     = 5'd3;
   localparam logic [4:0] OP_AND    = 5'd4;
   localparam logic [4:0] OP_SLL    = 5'd5;
   localparam logic [4:0] OP_SRL    = 5'd6;
   localparam logic [4:0] OP_SRA    = 5'd7;
   localparam logic [4:0] OP_SLT    = 5'd8;
   localparam logic [4:0] OP_SLTU   = 5'd9;
   localparam logic [4:0] OP_MUL    = 5'd16;
   localparam logic [4:0] OP_MULH   = 5'd17;
   localparam logic [4:0] OP_MULHSU = 5'd18;
   localparam logic [4:0] OP_MULHU  = 5'd19;
   localparam logic [4:0] OP_DIV    = 5'd20;
   localparam logic [4:0] OP_DIVU   = 5'd21;
   localparam logic [4:0] OP_REM    = 5'd22;
   localparam logic [4:0] OP_REMU   = 5'd23;

   // Widest XLEN the constant helpers below can describe.
   localparam int MAX_XLEN = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [MAX_XLEN-1:0] all_ones(input int w);
      return {MAX_XLEN{1'b1}} >> (MAX_XLEN - w);
   endfunction

   function automatic logic [MAX_XLEN-1:0] min_neg(input int w);
      return {{(MAX_XLEN-1){1'b0}}, 1'b1} << (w - 1);
   endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Request/response bundle between the issue stage and the alu_mdu execute unit.
interface alu_mdu_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [4:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            kill;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            busy;

   modport master (
      output in_valid, op, a, b, kill, out_ready,
      input  in_ready, out_valid, result, busy
   );

   modport slave (
      input  in_valid, op, a, b, kill, out_ready,
      output in_ready, out_valid, result, busy
   );
endinterface

// File: rtl/alu_mdu_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring-subtract step
// per cycle on operand magnitudes, with the sign fixed up on the final step.
module mdu_iter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            is_div,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            kill,
   output logic            done,
   output logic [XLEN-1:0] res
);
   localparam int SHW = $clog2(XLEN);

   logic            run_q, run_d;
   logic [SHW-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0] acc_q, acc_d, lo_q, lo_d, mc_q, mc_d;
   logic            div_q, div_d, hi_q, hi_d, rsel_q, rsel_d;
   logic            negq_q, negq_d, negr_q, negr_d;

   logic            a_sgn, b_sgn, a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic [XLEN:0]   sum, sh;
   logic            ge;
   logic [XLEN-1:0] acc_n, lo_n, quo_f, rem_f;
   logic [2*XLEN-1:0] prod, prod_f;

   // Multiply: op 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU. Divide: op[0]=unsigned, op[1]=remainder.
   always_comb begin
      a_sgn = is_div ? !op[0] : ((op == 2'b01) || (op == 2'b10));
      b_sgn = is_div ? !op[0] : (op == 2'b01);
      a_neg = a_sgn & a[XLEN-1];
      b_neg = b_sgn & b[XLEN-1];
      a_mag = a_neg ? -a : a;
      b_mag = b_neg ? -b : b;
   end

   always_comb begin
      sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mc_q} : '0);
      sh  = {acc_q, lo_q[XLEN-1]};
      ge  = (sh >= {1'b0, mc_q});
      if (div_q) begin
         acc_n = ge ? XLEN'(sh - {1'b0, mc_q}) : sh[XLEN-1:0];
         lo_n  = {lo_q[XLEN-2:0], ge};
      end else begin
         acc_n = sum[XLEN:1];
         lo_n  = {sum[0], lo_q[XLEN-1:1]};
      end
      prod   = {acc_n, lo_n};
      prod_f = negq_q ? -prod : prod;
      quo_f  = negq_q ? -lo_n : lo_n;
      rem_f  = negr_q ? -acc_n : acc_n;
      if (div_q) res = rsel_q ? rem_f : quo_f;
      else       res = hi_q ? prod_f[2*XLEN-1:XLEN] : prod_f[XLEN-1:0];
      done = run_q && (cnt_q == '0);
   end

   always_comb begin
      run_d  = run_q;
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      lo_d   = lo_q;
      mc_d   = mc_q;
      div_d  = div_q;
      hi_d   = hi_q;
      rsel_d = rsel_q;
      negq_d = negq_q;
      negr_d = negr_q;
      if (start) begin
         run_d  = 1'b1;
         cnt_d  = SHW'(XLEN - 1);
         acc_d  = '0;
         lo_d   = is_div ? a_mag : b_mag;
         mc_d   = is_div ? b_mag : a_mag;
         div_d  = is_div;
         hi_d   = !is_div && (op != 2'b00);
         rsel_d = is_div && op[1];
         negq_d = a_neg ^ b_neg;
         negr_d = a_neg;
      end else if (run_q) begin
         acc_d = acc_n;
         lo_d  = lo_n;
         if (cnt_q == '0) run_d = 1'b0;
         else             cnt_d = cnt_q - SHW'(1);
      end
      if (kill) run_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         run_q <= run_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      acc_q  <= acc_d;
      lo_q   <= lo_d;
      mc_q   <= mc_d;
      div_q  <= div_d;
      hi_q   <= hi_d;
      rsel_q <= rsel_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
   end

endmodule

// File: rtl/alu_mdu.sv
// Handshaked RV32I/RV32M execute unit: single-cycle base ops and divide
// special cases, iterative MUL*/DIV*/REM* through mdu_iter, flushable by kill.
module alu_mdu #(
   parameter int XLEN = 32
) (
   input logic      clk,
   input logic      rst_n,
   alu_mdu_if.slave bus
);
   import alu_mdu_pkg::*;

   localparam int SHW = $clog2(XLEN);
   localparam logic [XLEN-1:0] ALL_ONES = XLEN'(all_ones(XLEN));
   localparam logic [XLEN-1:0] MIN_NEG  = XLEN'(min_neg(XLEN));

   state_t          state_q, state_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [XLEN-1:0] base_res, spec_res, iter_res;
   logic            accept, is_m, is_div, special, start, iter_done;
   logic [SHW-1:0]  shamt;
   logic signed [XLEN-1:0] a_s, b_s;

   assign bus.in_ready  = (state_q == IDLE) && !bus.kill;
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q == ITER);
   assign bus.result    = result_q;

   assign accept = bus.in_valid && bus.in_ready;
   assign is_m   = (bus.op[4:3] == 2'b10);
   assign is_div = bus.op[2];
   assign shamt  = bus.b[SHW-1:0];
   assign a_s    = bus.a;
   assign b_s    = bus.b;

   // Divide by zero and signed overflow are answered directly, without iterating.
   assign special = is_m && is_div &&
                    ((bus.b == '0) || (!bus.op[0] && (bus.a == MIN_NEG) && (bus.b == ALL_ONES)));
   assign spec_res = (bus.b == '0) ? (bus.op[1] ? bus.a : ALL_ONES)
                                   : (bus.op[1] ? '0 : MIN_NEG);
   assign start = accept && is_m && !special;

   always_comb begin
      base_res = '0;
      case (bus.op)
         OP_ADD:  base_res = bus.a + bus.b;
         OP_SUB:  base_res = bus.a - bus.b;
         OP_XOR:  base_res = bus.a ^ bus.b;
         OP_OR:   base_res = bus.a | bus.b;
         OP_AND:  base_res = bus.a & bus.b;
         OP_SLL:  base_res = bus.a << shamt;
         OP_SRL:  base_res = bus.a >> shamt;
         OP_SRA:  base_res = a_s >>> shamt;
         OP_SLT:  base_res = {{(XLEN-1){1'b0}}, (a_s < b_s)};
         OP_SLTU: base_res = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
         default: base_res = '0;
      endcase
   end

   mdu_iter #(.XLEN(XLEN)) u_iter (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .is_div (is_div),
      .op     (bus.op[1:0]),
      .a      (bus.a),
      .b      (bus.b),
      .kill   (bus.kill),
      .done   (iter_done),
      .res    (iter_res)
   );

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (start) begin
                  state_d = ITER;
               end else begin
                  state_d  = DONE;
                  result_d = is_m ? spec_res : base_res;
               end
            end
         end
         ITER: begin
            if (iter_done) begin
               state_d  = DONE;
               result_d = iter_res;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (bus.kill) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
      end
   end

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: directed vector table, randomized ops against a reference
// model, and hand sequences for reset, back-pressure, kill and XLEN=64 latency.
module tb_alu_mdu;
   import alu_mdu_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_mdu_if #(.XLEN(32)) bus32 ();
   alu_mdu_if #(.XLEN(64)) bus64 ();

   alu_mdu #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
   alu_mdu #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
   } vec_t;

   vec_t vt [16];
   logic [4:0] op_pool [0:18] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                  5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd13};

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      longint unsigned ua, ub;
      logic [63:0] p;
      logic [4:0] sh;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      sh = b[4:0];
      p  = '0;
      case (op)
         OP_ADD:    return a + b;
         OP_SUB:    return a - b;
         OP_XOR:    return a ^ b;
         OP_OR:     return a | b;
         OP_AND:    return a & b;
         OP_SLL:    return a << sh;
         OP_SRL:    return a >> sh;
         OP_SRA:    begin p = sa >>> sh; return p[31:0]; end
         OP_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
         OP_SLTU:   return (ua < ub) ? 32'd1 : 32'd0;
         OP_MUL:    begin p = ua * ub; return p[31:0]; end
         OP_MULH:   begin p = sa * sb; return p[63:32]; end
         OP_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
         OP_MULHU:  begin p = ua * ub; return p[63:32]; end
         OP_DIV: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            p = sa / sb;
            return p[31:0];
         end
         OP_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         OP_REM: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            p = sa % sb;
            return p[31:0];
         end
         OP_REMU:   return (b == 32'd0) ? a : a % b;
         default:   return 32'd0;
      endcase
   endfunction

   function automatic int model_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op < 5'd16 || op > 5'd23) return 1;
      if (op >= 5'd20) begin
         if (b == 32'd0) return 1;
         if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      end
      return 33;
   endfunction

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Issue one op, scramble the inputs after accept, wait for the result and take it.
   task automatic run32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busy_n);
      bus32.in_valid = 1'b1;
      bus32.op = op;
      bus32.a  = a;
      bus32.b  = b;
      step();
      bus32.in_valid = 1'b0;
      bus32.op = 5'($urandom);
      bus32.a  = $urandom;
      bus32.b  = $urandom;
      lat = 1;
      busy_n = 0;
      while (!bus32.out_valid && lat < 200) begin
         if (bus32.busy) busy_n++;
         step();
         lat++;
      end
      res = bus32.result;
      bus32.out_ready = 1'b1;
      step();
      bus32.out_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r, a, b, held;
      logic [4:0]  op;
      logic [63:0] a64, b64;
      logic [127:0] p128;
      int lat, busy_n, n;
      logic seen;

      vt[0]  = '{OP_ADD,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1};
      vt[1]  = '{OP_SRA,    32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1};
      vt[2]  = '{OP_SLT,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1};
      vt[3]  = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
      vt[4]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
      vt[5]  = '{OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
      vt[6]  = '{OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
      vt[7]  = '{OP_DIVU,   32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1};
      vt[8]  = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
      vt[9]  = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
      vt[10] = '{OP_SLTU,   32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1};
      vt[11] = '{5'd12,     32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1};
      vt[12] = '{OP_MUL,    32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, 33};
      vt[13] = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
      vt[14] = '{OP_REMU,   32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1};
      vt[15] = '{OP_SLL,    32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1};

      rst_n = 1'b0;
      bus32.in_valid = 1'b0; bus32.op = '0; bus32.a = '0; bus32.b = '0;
      bus32.kill = 1'b0; bus32.out_ready = 1'b0;
      bus64.in_valid = 1'b0; bus64.op = '0; bus64.a = '0; bus64.b = '0;
      bus64.kill = 1'b0; bus64.out_ready = 1'b0;
      #1;
      check("reset in_ready", 64'(bus32.in_ready), 64'd1);
      check("reset out_valid", 64'(bus32.out_valid), 64'd0);
      check("reset busy", 64'(bus32.busy), 64'd0);
      check("reset result", 64'(bus32.result), 64'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      check("post-reset in_ready", 64'(bus32.in_ready), 64'd1);
      check("post-reset in_ready64", 64'(bus64.in_ready), 64'd1);

      for (int i = 0; i < 16; i++) begin
         run32(vt[i].op, vt[i].a, vt[i].b, r, lat, busy_n);
         check($sformatf("vec%0d result", i), 64'(r), 64'(vt[i].res));
         check($sformatf("vec%0d latency", i), 64'(lat), 64'(vt[i].lat));
      end

      for (int i = 0; i < 80; i++) begin
         op = op_pool[$urandom_range(0, 18)];
         a  = rnd_operand();
         b  = rnd_operand();
         run32(op, a, b, r, lat, busy_n);
         check($sformatf("rnd%0d op%0d result", i, op), 64'(r), 64'(model(op, a, b)));
         check($sformatf("rnd%0d op%0d latency", i, op), 64'(lat), 64'(model_lat(op, a, b)));
         check($sformatf("rnd%0d op%0d busy cycles", i, op), 64'(busy_n),
               64'((model_lat(op, a, b) == 33) ? 32 : 0));
      end

      // Reset asserted in the tenth busy cycle of a DIV.
      bus32.in_valid = 1'b1; bus32.op = OP_DIV; bus32.a = 32'h1234_5678; bus32.b = 32'd3;
      step();
      bus32.in_valid = 1'b0;
      repeat (9) step();
      check("div busy at cycle 10", 64'(bus32.busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async reset busy", 64'(bus32.busy), 64'd0);
      check("async reset out_valid", 64'(bus32.out_valid), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      check("release in_ready", 64'(bus32.in_ready), 64'd1);
      check("release out_valid", 64'(bus32.out_valid), 64'd0);
      check("release result", 64'(bus32.result), 64'd0);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (bus32.out_valid || bus32.busy) seen = 1'b1;
      end
      check("no stale result after reset", 64'(seen), 64'd0);

      // Back-pressure on a completed DIVU.
      bus32.in_valid = 1'b1; bus32.op = OP_DIVU; bus32.a = 32'd100; bus32.b = 32'd7;
      step();
      bus32.in_valid = 1'b0;
      n = 0;
      while (!bus32.out_valid && n < 200) begin step(); n++; end
      check("divu completes", 64'(bus32.out_valid), 64'd1);
      held = bus32.result;
      check("divu result", 64'(held), 64'd14);
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("stall%0d result", i), 64'(bus32.result), 64'(held));
         check($sformatf("stall%0d in_ready", i), 64'(bus32.in_ready), 64'd0);
         check($sformatf("stall%0d out_valid", i), 64'(bus32.out_valid), 64'd1);
      end
      bus32.out_ready = 1'b1;
      step();
      bus32.out_ready = 1'b0;
      check("after take in_ready", 64'(bus32.in_ready), 64'd1);
      check("after take out_valid", 64'(bus32.out_valid), 64'd0);

      // kill at busy cycle 12 with a competing request.
      bus32.in_valid = 1'b1; bus32.op = OP_MUL; bus32.a = 32'd1234; bus32.b = 32'd5678;
      step();
      bus32.in_valid = 1'b0;
      repeat (11) step();
      check("mul busy at cycle 12", 64'(bus32.busy), 64'd1);
      bus32.kill = 1'b1;
      bus32.in_valid = 1'b1; bus32.op = OP_ADD; bus32.a = 32'd1; bus32.b = 32'd2;
      #1;
      check("kill blocks in_ready", 64'(bus32.in_ready), 64'd0);
      step();
      bus32.kill = 1'b0;
      bus32.in_valid = 1'b0;
      #1;
      check("after kill busy", 64'(bus32.busy), 64'd0);
      check("after kill out_valid", 64'(bus32.out_valid), 64'd0);
      check("after kill in_ready", 64'(bus32.in_ready), 64'd1);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (bus32.out_valid) seen = 1'b1;
      end
      check("no result after kill", 64'(seen), 64'd0);

      // kill while a result is waiting discards it.
      bus32.in_valid = 1'b1; bus32.op = OP_XOR; bus32.a = 32'hF0F0_F0F0; bus32.b = 32'h0FF0_0FF0;
      step();
      bus32.in_valid = 1'b0;
      check("xor result", 64'(bus32.result), 64'hFF00_FF00);
      bus32.kill = 1'b1;
      step();
      bus32.kill = 1'b0;
      #1;
      check("kill in done out_valid", 64'(bus32.out_valid), 64'd0);
      check("kill in done in_ready", 64'(bus32.in_ready), 64'd1);

      // XLEN=64 multiply latency and products.
      for (int i = 0; i < 4; i++) begin
         a64 = (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
         b64 = (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
         op  = (i % 2 == 0) ? OP_MUL : OP_MULHU;
         p128 = {64'b0, a64} * {64'b0, b64};
         bus64.in_valid = 1'b1; bus64.op = op; bus64.a = a64; bus64.b = b64;
         step();
         bus64.in_valid = 1'b0; bus64.a = '0; bus64.b = '0;
         lat = 1;
         while (!bus64.out_valid && lat < 300) begin step(); lat++; end
         check($sformatf("x64 op%0d latency", op), 64'(lat), 64'd65);
         check($sformatf("x64 op%0d result", op), bus64.result,
               (op == OP_MUL) ? p128[63:0] : p128[127:64]);
         bus64.out_ready = 1'b1;
         step();
         bus64.out_ready = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
